// File: rtl/fetch_if.sv
// Fetch-stage bus: hazard controls, execute redirect, instruction-memory port and IF/ID outputs.
interface fetch_if;
  logic        stall_f;
  logic        stall_d;
  logic        flush_d;
  logic        jumppc_e;
  logic [31:0] pctarget_e;
  logic [31:0] imem_addr_f;
  logic [31:0] imem_rdata_f;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pcplus4_d;
  logic        valid_d;

  modport master (
    output stall_f, stall_d, flush_d, jumppc_e, pctarget_e, imem_rdata_f,
    input  imem_addr_f, instr_d, pc_d, pcplus4_d, valid_d
  );

  modport slave (
    input  stall_f, stall_d, flush_d, jumppc_e, pctarget_e, imem_rdata_f,
    output imem_addr_f, instr_d, pc_d, pcplus4_d, valid_d
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch + IF/ID register. Optional FETCH_PERF_CNT_EN adds bubble_cnt/fetch_cnt counters.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] bubble_cnt,
  output logic [31:0] fetch_cnt,
`endif
  fetch_if.slave      bus
);

  typedef enum logic {BOOT, RUN} state_t;

  state_t      state;
  logic [31:0] pc_f;
  logic [31:0] instr_q, pc_q, pcplus4_q;
  logic        valid_q;

  logic        kill_d;
  logic        load_d;

  // A redirect always discards the wrong-path word currently in fetch.
  assign kill_d = bus.jumppc_e | bus.flush_d;
  assign load_d = (state == RUN) & ~kill_d & ~bus.stall_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= BOOT;
      pc_f      <= RESET_PC;
      instr_q   <= NOP_INSTR;
      pc_q      <= 32'd0;
      pcplus4_q <= 32'd4;
      valid_q   <= 1'b0;
    end else begin
      state <= RUN;
      // BOOT holds the PC so RESET_PC is fetched into the first real load.
      if (bus.jumppc_e)
        pc_f <= {bus.pctarget_e[31:2], 2'b00};
      else if (state == RUN && !bus.stall_f)
        pc_f <= pc_f + 32'd4;

      if (state == RUN) begin
        if (kill_d) begin
          instr_q   <= NOP_INSTR;
          pc_q      <= 32'd0;
          pcplus4_q <= 32'd4;
          valid_q   <= 1'b0;
        end else if (!bus.stall_d) begin
          instr_q   <= bus.imem_rdata_f;
          pc_q      <= pc_f;
          pcplus4_q <= pc_f + 32'd4;
          valid_q   <= 1'b1;
        end
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bubble_cnt <= 32'd0;
      fetch_cnt  <= 32'd0;
    end else begin
      if (state == RUN && kill_d) bubble_cnt <= bubble_cnt + 32'd1;
      if (load_d)                 fetch_cnt  <= fetch_cnt + 32'd1;
    end
  end
`endif

  assign bus.imem_addr_f = pc_f;
  assign bus.instr_d     = instr_q;
  assign bus.pc_d        = pc_q;
  assign bus.pcplus4_d   = pcplus4_q;
  assign bus.valid_d     = valid_q;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage and IF/ID pipeline register of the five-stage RISC-V core. It owns the program counter, drives the instruction-memory address, and delivers the fetched instruction to the decode stage, where the control unit decodes its opcode field. It also applies stalls, flushes and execute-stage redirects (jumps/branches). Whenever no valid instruction is available, it inserts the canonical NOP (addi x0, x0, 0) into decode.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0).
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- stall_f  in  1  hold pc_f (from hazard unit).
- stall_d  in  1  hold IF/ID register.
- flush_d  in  1  replace IF/ID contents with a bubble.
- jumppc_e  in  1  redirect request from execute.
- pctarget_e  in  32  redirect target.
- imem_addr_f  out  32  instruction-memory address, equal to pc_f (combinational).
- imem_rdata_f  in  32  instruction word, combinational read of imem_addr_f.
- instr_d  out  32  instruction to decode; opcode_d = instr_d[6:0].
- pc_d  out  32  PC of instr_d.
- pcplus4_d  out  32  pc_d + 4.
- valid_d  out  1  1 = real instruction, 0 = bubble.

## Operation
- Internal state: pc_f (32b), IF/ID register (instr_d, pc_d, pcplus4_d, valid_d), and a 2-state FSM {BOOT, RUN}.
- BOOT is entered on reset and lasts exactly one cycle. During BOOT the unit presents pc_f = RESET_PC to memory and does not load IF/ID, which keeps its bubble. BOOT always advances to RUN. RUN persists until reset.
- PC next-state, highest priority first:
  - reset: RESET_PC.
  - jumppc_e: {pctarget_e[31:2], 2'b00}. The low bits are forced to zero and there is no misalign trap.
  - stall_f: hold.
  - otherwise: pc_f + 4, modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000).
- IF/ID next-state in RUN, highest priority first:
  - reset: bubble.
  - jumppc_e or flush_d: bubble. Jump implies flush of the wrong-path fetch.
  - stall_d: hold all fields.
  - otherwise: load imem_rdata_f, pc_f, pc_f+4, valid=1.
- Bubble is defined as instr_d = NOP_INSTR, pc_d = 0, pcplus4_d = 4, valid_d = 0.
- A flush during a stall always wins (flush_d & stall_d -> bubble).
- stall_f without stall_d is legal: the hazard unit must not request it, but if it occurs the same instruction is loaded twice. No protection is provided.
- jumppc_e during BOOT: pc_f takes the target and IF/ID stays a bubble. The FSM still goes to RUN.

## Timing
- Reset values: pc_f = RESET_PC, imem_addr_f = RESET_PC, instr_d = 32'h0000_0013, pc_d = 0, pcplus4_d = 4, valid_d = 0, FSM = BOOT.
- First real instruction appears at decode 2 edges after rst_n rises: edge 1 leaves BOOT, edge 2 loads IF/ID.
- Fetch-to-decode latency is 1 cycle. Memory read is combinational and same-cycle.
- Redirect penalty: with jumppc_e high in cycle N, the target instruction reaches decode after edge N+2, and decode holds a bubble for one cycle after edge N+1.
- Reset asserted mid-stream takes effect on the next edge, regardless of stall, flush or jump.

## Configuration
- FETCH_PERF_CNT_EN:
  - Defined: adds output bubble_cnt (out, 32) and register fetch_cnt (out, 32).
    - bubble_cnt increments on every edge in RUN where IF/ID loads a bubble.
    - fetch_cnt increments on every edge where IF/ID loads valid=1.
    - Both counters reset to 0 and wrap modulo 2^32.
  - Undefined: neither the ports nor the counters exist, and functional behaviour is identical.

## Test plan
- Reset release, RESET_PC=0, memory word k = 0x00000033+(k<<7): after 2 edges, instr_d = mem[0] with valid_d = 1; then pc_d = 0, 4, 8 on consecutive edges, with opcode_d = 7'b0110011 each time.
- Reset held: instr_d = 0x00000013 and valid_d = 0 at every edge; imem_addr_f = 0.
- stall_f and stall_d high for 3 cycles at pc_f = 0x10: imem_addr_f stays 0x10 and instr_d/pc_d hold. On release, pc_d advances to 0x10.
- jumppc_e = 1 with pctarget_e = 0x0000_0103: next imem_addr_f = 0x100 and decode gets one bubble. Then pc_d = 0x100 with pcplus4_d = 0x104.
- flush_d and stall_d asserted together: the next edge gives instr_d = 0x00000013, valid_d = 0 (flush wins).
- PC at 0xFFFF_FFFC with no stall: next imem_addr_f = 0x0000_0000. With FETCH_PERF_CNT_EN, the fetch_cnt/bubble_cnt totals match the counted loads.
